regdump_scanner: RTL

REGDUMP_SCANNER -- requirements
Module: regdump_scanner

---
 rtl/regdump_scanner_if.sv | 30 +++
 rtl/regdump_scanner.sv | 98 +++++++++
 2 files changed

// File: rtl/regdump_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : regdump_scanner_if
//  Description : Bundle of the scanner's control, register-file test port and
//                byte-stream handshake signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regdump_scanner_if;
  logic        start;
  logic [4:0]  test_reg;
  logic [31:0] test_dat;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  // Scanner side: drives the register index and the byte stream.
  modport master (
    input  start, test_dat, out_ready,
    output test_reg, out_byte, out_valid, busy, done
  );

  // Environment side: register file, byte sink and controller.
  modport slave (
    output start, test_dat, out_ready,
    input  test_reg, out_byte, out_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/regdump_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : regdump_scanner
//  Description : Walks registers FIRST_REG..LAST_REG through the register
//                file test read port and streams each one as five bytes:
//                index byte, then the 32-bit value MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module regdump_scanner #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              resetn,
  regdump_scanner_if.master bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_send = 2'd2;
  localparam logic [1:0] c_st_fin  = 2'd3;

  localparam logic [4:0] c_first    = 5'(FIRST_REG);
  localparam logic [4:0] c_last     = 5'(LAST_REG);
  localparam logic [2:0] c_last_bcnt = 3'd4;

  logic [1:0]  r_state;
  logic [4:0]  r_idx;
  logic [2:0]  r_bcnt;
  logic [31:0] r_hold;
  logic [7:0]  w_byte;

  // Sequencer: capture a register in LOAD, emit its five bytes in SEND,
  // advance to the next register or finish after the last byte.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= c_st_idle;
      r_idx   <= c_first;
      r_bcnt  <= 3'd0;
      r_hold  <= 32'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (bus.start) begin
            r_idx   <= c_first;
            r_state <= c_st_load;
          end
        end
        c_st_load: begin
          r_hold  <= bus.test_dat;
          r_bcnt  <= 3'd0;
          r_state <= c_st_send;
        end
        c_st_send: begin
          if (bus.out_ready) begin
            if (r_bcnt != c_last_bcnt) begin
              r_bcnt <= r_bcnt + 3'd1;
            end else if (r_idx < c_last) begin
              r_idx   <= r_idx + 5'd1;
              r_state <= c_st_load;
            end else begin
              r_state <= c_st_fin;
            end
          end
        end
        c_st_fin: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Byte selection: index byte first, then held data MSB first; zero when idle.
  always_comb begin
    w_byte = 8'h00;
    if (r_state == c_st_send) begin
      case (r_bcnt)
        3'd0:    w_byte = {3'b000, r_idx};
        3'd1:    w_byte = r_hold[31:24];
        3'd2:    w_byte = r_hold[23:16];
        3'd3:    w_byte = r_hold[15:8];
        3'd4:    w_byte = r_hold[7:0];
        default: w_byte = 8'h00;
      endcase
    end
  end

  assign bus.test_reg  = r_idx;
  assign bus.out_byte  = w_byte;
  assign bus.out_valid = (r_state == c_st_send);
  assign bus.busy      = (r_state != c_st_idle);
  assign bus.done      = (r_state == c_st_fin);

endmodule
`default_nettype wire
